// File: rtl/bcd_clock_core_pkg.sv
// Shared BCD field widths, digit/hour limits and bit positions for the BCD clock core.
package bcd_clock_core_pkg;

  localparam int unsigned DigitW = 4;

  typedef logic [DigitW-1:0] bcdDigit;

  localparam bcdDigit    TensMax   = 4'd5;
  localparam bcdDigit    UnitsMax  = 4'd9;
  localparam logic [7:0] Hour24Max = 8'd23;
  localparam logic [7:0] Hour12Max = 8'd12;

  // Nibble positions inside the 24-bit HH:MM:SS word
  localparam int unsigned HTensPos  = 20;
  localparam int unsigned HUnitsPos = 16;
  localparam int unsigned MTensPos  = 12;
  localparam int unsigned MUnitsPos = 8;
  localparam int unsigned STensPos  = 4;
  localparam int unsigned SUnitsPos = 0;

  function automatic logic [7:0] bcdToBin(input logic [7:0] b);
    return {4'd0, b[7:4]} * 8'd10 + {4'd0, b[3:0]};
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counting 0..MAX with synchronous load/clear and a wrap carry.
module bcd_digit_counter
  import bcd_clock_core_pkg::*;
#(
  parameter bcdDigit MAX = UnitsMax
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    inc,
  input  logic    clr,
  input  logic    load,
  input  bcdDigit load_val,
  output bcdDigit value,
  output logic    carry
);

  bcdDigit valueQ;

  assign carry = inc && (valueQ == MAX);
  assign value = valueQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valueQ <= '0;
    end else if (load) begin
      valueQ <= load_val;
    end else if (clr) begin
      valueQ <= '0;
    end else if (inc) begin
      valueQ <= (valueQ == MAX) ? 4'd0 : valueQ + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_clock_core.sv
// BCD time-of-day core: prescaled second advance, validated load, manual min/hour bumps.
module bcd_clock_core
  import bcd_clock_core_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter bit          MODE_12H = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [23:0] load_time,
  input  logic        load_pm,
  input  logic        inc_min,
  input  logic        inc_hour,
  output logic [23:0] time_out,
  output logic        pm,
  output logic        sec_tick,
  output logic        day_tick,
  output logic        load_err
);

  localparam int unsigned      PrescW    = $clog2(TICK_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
  localparam logic [7:0]       HourReset = MODE_12H ? 8'h12 : 8'h00;

  logic [PrescW-1:0] prescQ;
  logic [7:0]        hourQ;
  logic              pmQ, secTickQ, dayTickQ, loadErrQ;

  bcdDigit ldHT, ldHU, ldMT, ldMU, ldST, ldSU;
  bcdDigit secU, secT, minU, minT;
  logic    secUCarry, secTCarry, minUCarry, minTCarry;
  logic    loadOk, loadAcc, loadRej, secAdv, hourRoll, hourStep, pmFlip, atDayEnd;
  logic [7:0] ldHourBin, hourBin;

  assign ldHT = load_time[HTensPos  +: DigitW];
  assign ldHU = load_time[HUnitsPos +: DigitW];
  assign ldMT = load_time[MTensPos  +: DigitW];
  assign ldMU = load_time[MUnitsPos +: DigitW];
  assign ldST = load_time[STensPos  +: DigitW];
  assign ldSU = load_time[SUnitsPos +: DigitW];

  assign ldHourBin = bcdToBin({ldHT, ldHU});
  assign hourBin   = bcdToBin(hourQ);

  always_comb begin
    loadOk = (ldHT <= UnitsMax) && (ldHU <= UnitsMax) && (ldMU <= UnitsMax) &&
             (ldSU <= UnitsMax) && (ldMT <= TensMax) && (ldST <= TensMax);
    if (MODE_12H) begin
      loadOk = loadOk && (ldHourBin >= 8'd1) && (ldHourBin <= Hour12Max);
    end else begin
      loadOk = loadOk && (ldHourBin <= Hour24Max);
    end
  end

  assign load_ready = !run;
  assign loadAcc    = load_valid && load_ready && loadOk;
  assign loadRej    = load_valid && load_ready && !loadOk;

  // A second lost to a load or a manual bump is dropped, not deferred
  assign secAdv   = run && (prescQ == PrescMax) && !loadAcc && !inc_min && !inc_hour;
  // inc_min wrapping 59 -> 00 must not spill into the hour
  assign hourRoll = minTCarry && !inc_min;
  assign hourStep = hourRoll || inc_hour;
  assign pmFlip   = MODE_12H && (hourBin == 8'd11);
  assign atDayEnd = MODE_12H ? ((hourBin == 8'd11) && pmQ) : (hourBin == Hour24Max);

  function automatic logic [7:0] nextHour(input logic [7:0] h);
    logic [7:0] n;
    if (MODE_12H && (bcdToBin(h) == Hour12Max)) begin
      n = 8'h01;
    end else if (!MODE_12H && (bcdToBin(h) == Hour24Max)) begin
      n = 8'h00;
    end else if (h[3:0] == UnitsMax) begin
      n = {h[7:4] + 4'd1, 4'd0};
    end else begin
      n = {h[7:4], h[3:0] + 4'd1};
    end
    return n;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescQ <= '0;
    end else if (loadAcc) begin
      prescQ <= '0;
    end else if (run) begin
      prescQ <= (prescQ == PrescMax) ? '0 : prescQ + PrescW'(1);
    end
  end

  bcd_digit_counter #(.MAX(UnitsMax)) uSecU (
    .clk(clk), .reset(reset), .inc(secAdv), .clr(1'b0), .load(loadAcc),
    .load_val(ldSU), .value(secU), .carry(secUCarry)
  );

  bcd_digit_counter #(.MAX(TensMax)) uSecT (
    .clk(clk), .reset(reset), .inc(secUCarry), .clr(1'b0), .load(loadAcc),
    .load_val(ldST), .value(secT), .carry(secTCarry)
  );

  bcd_digit_counter #(.MAX(UnitsMax)) uMinU (
    .clk(clk), .reset(reset), .inc(secTCarry || inc_min), .clr(1'b0), .load(loadAcc),
    .load_val(ldMU), .value(minU), .carry(minUCarry)
  );

  bcd_digit_counter #(.MAX(TensMax)) uMinT (
    .clk(clk), .reset(reset), .inc(minUCarry), .clr(1'b0), .load(loadAcc),
    .load_val(ldMT), .value(minT), .carry(minTCarry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hourQ    <= HourReset;
      pmQ      <= 1'b0;
      secTickQ <= 1'b0;
      dayTickQ <= 1'b0;
      loadErrQ <= 1'b0;
    end else begin
      secTickQ <= secAdv;
      dayTickQ <= hourRoll && atDayEnd;
      loadErrQ <= loadRej;
      if (loadAcc) begin
        hourQ <= {ldHT, ldHU};
        pmQ   <= MODE_12H ? load_pm : 1'b0;
      end else if (hourStep) begin
        hourQ <= nextHour(hourQ);
        if (pmFlip) pmQ <= ~pmQ;
      end
    end
  end

  assign time_out = {hourQ, minT, minU, secT, secU};
  assign pm       = pmQ;
  assign sec_tick = secTickQ;
  assign day_tick = dayTickQ;
  assign load_err = loadErrQ;

endmodule

// File: tb/tb_bcd_clock_core.sv
// Bench for bcd_clock_core: 24h and 12h instances share stimulus; seconds-of-day reference model.
module tb_bcd_clock_core;

  localparam int TickDiv = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        loadValid = 1'b0;
  logic [23:0] loadTime = '0;
  logic        loadPm = 1'b0;
  logic        incMin = 1'b0;
  logic        incHour = 1'b0;

  logic        ready24, pm24, st24, dt24, err24;
  logic        ready12, pm12, st12, dt12, err12;
  logic [23:0] time24, time12;

  int compared = 0;
  int mismatched = 0;

  // Reference state: seconds since midnight per instance (0 = 24h, 1 = 12h)
  int sod[2];
  int presc[2];
  bit expSt[2], expDt[2], expErr[2];

  always #5 clk = ~clk;

  bcd_clock_core #(.TICK_DIV(TickDiv), .MODE_12H(1'b0)) dut24 (
    .clk(clk), .reset(reset), .run(run), .load_valid(loadValid), .load_ready(ready24),
    .load_time(loadTime), .load_pm(loadPm), .inc_min(incMin), .inc_hour(incHour),
    .time_out(time24), .pm(pm24), .sec_tick(st24), .day_tick(dt24), .load_err(err24)
  );

  bcd_clock_core #(.TICK_DIV(TickDiv), .MODE_12H(1'b1)) dut12 (
    .clk(clk), .reset(reset), .run(run), .load_valid(loadValid), .load_ready(ready12),
    .load_time(loadTime), .load_pm(loadPm), .inc_min(incMin), .inc_hour(incHour),
    .time_out(time12), .pm(pm12), .sec_tick(st12), .day_tick(dt12), .load_err(err12)
  );

  function automatic logic [23:0] toBcd(input int s, input bit m12);
    int h, mi, se;
    h  = s / 3600;
    mi = (s / 60) % 60;
    se = s % 60;
    if (m12) h = (h % 12 == 0) ? 12 : h % 12;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
  endfunction

  function automatic bit parseLoad(input logic [23:0] t, input bit p, input bit m12,
                                   output int s);
    int d[6];
    int h;
    s = 0;
    for (int i = 0; i < 6; i++) d[i] = int'(t[i*4 +: 4]);
    for (int i = 0; i < 6; i++) if (d[i] > 9) return 1'b0;
    if (d[1] > 5 || d[3] > 5) return 1'b0;
    h = d[5] * 10 + d[4];
    if (m12) begin
      if (h < 1 || h > 12) return 1'b0;
      h = h % 12 + (p ? 12 : 0);
    end else if (h > 23) begin
      return 1'b0;
    end
    s = h * 3600 + (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
    return 1'b1;
  endfunction

  function automatic logic [23:0] randTime();
    logic [23:0] r;
    case ($urandom_range(0, 3))
      0: r = 24'($urandom);
      1: r = toBcd(($urandom_range(0, 1) ? 86390 : 43190) + $urandom_range(0, 9),
                   1'($urandom_range(0, 1)));
      default: r = toBcd($urandom_range(0, 86399), 1'($urandom_range(0, 1)));
    endcase
    return r;
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      sod[m] = 0; presc[m] = 0; expSt[m] = 0; expDt[m] = 0; expErr[m] = 0;
    end
  endtask

  task automatic modelStep();
    for (int m = 0; m < 2; m++) begin
      int ls;
      bit ok, acc, adv;
      ok = parseLoad(loadTime, loadPm, m == 1, ls);
      acc = loadValid && !run && ok;
      expErr[m] = loadValid && !run && !ok;
      adv = run && presc[m] == TickDiv - 1;
      expSt[m] = 0;
      expDt[m] = 0;
      if (acc) begin
        sod[m] = ls;
        presc[m] = 0;
      end else begin
        if (run) presc[m] = (presc[m] + 1) % TickDiv;
        if (incHour || incMin) begin
          if (incHour) sod[m] = (sod[m] + 3600) % 86400;
          if (incMin) begin
            int mi;
            mi = (sod[m] / 60) % 60;
            sod[m] = sod[m] - mi * 60 + ((mi + 1) % 60) * 60;
          end
        end else if (adv) begin
          expSt[m] = 1;
          expDt[m] = (sod[m] == 86399);
          sod[m] = (sod[m] + 1) % 86400;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    check({tag, "_24"}, 32'({time24, pm24, st24, dt24, err24, ready24}),
          32'({toBcd(sod[0], 1'b0), 1'b0, expSt[0], expDt[0], expErr[0], !run}));
    check({tag, "_12"}, 32'({time12, pm12, st12, dt12, err12, ready12}),
          32'({toBcd(sod[1], 1'b1), sod[1] >= 43200, expSt[1], expDt[1], expErr[1], !run}));
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
    checkModel("model");
  endtask

  task automatic setIn(input bit r, input bit lv, input logic [23:0] lt, input bit lp,
                       input bit im, input bit ih);
    run = r; loadValid = lv; loadTime = lt; loadPm = lp; incMin = im; incHour = ih;
  endtask

  typedef struct {
    bit          run;
    bit          lv;
    logic [23:0] lt;
    bit          im;
    bit          ih;
    logic [23:0] expTime;
    bit          expSt;
    bit          expDt;
    bit          expErr;
  } vec_t;

  vec_t vecs[22];
  int   n;
  bit   runBurst;

  initial begin
    vecs[0]  = '{0, 1, 24'h235958, 0, 0, 24'h235958, 0, 0, 0};
    vecs[1]  = '{1, 0, 24'h000000, 0, 0, 24'h235958, 0, 0, 0};
    vecs[2]  = '{1, 0, 24'h000000, 0, 0, 24'h235958, 0, 0, 0};
    vecs[3]  = '{1, 0, 24'h000000, 0, 0, 24'h235958, 0, 0, 0};
    vecs[4]  = '{1, 0, 24'h000000, 0, 0, 24'h235959, 1, 0, 0};
    vecs[5]  = '{1, 0, 24'h000000, 0, 0, 24'h235959, 0, 0, 0};
    vecs[6]  = '{1, 0, 24'h000000, 0, 0, 24'h235959, 0, 0, 0};
    vecs[7]  = '{1, 0, 24'h000000, 0, 0, 24'h235959, 0, 0, 0};
    vecs[8]  = '{1, 0, 24'h000000, 0, 0, 24'h000000, 1, 1, 0};
    vecs[9]  = '{0, 1, 24'h240000, 0, 0, 24'h000000, 0, 0, 1};
    vecs[10] = '{0, 1, 24'h126A00, 0, 0, 24'h000000, 0, 0, 1};
    vecs[11] = '{1, 1, 24'h123456, 0, 0, 24'h000000, 0, 0, 0};
    vecs[12] = '{0, 1, 24'h105930, 0, 0, 24'h105930, 0, 0, 0};
    vecs[13] = '{1, 0, 24'h000000, 0, 0, 24'h105930, 0, 0, 0};
    vecs[14] = '{1, 0, 24'h000000, 0, 0, 24'h105930, 0, 0, 0};
    vecs[15] = '{1, 0, 24'h000000, 0, 0, 24'h105930, 0, 0, 0};
    vecs[16] = '{1, 0, 24'h000000, 1, 0, 24'h100030, 0, 0, 0};
    vecs[17] = '{0, 1, 24'h230000, 0, 0, 24'h230000, 0, 0, 0};
    vecs[18] = '{0, 0, 24'h000000, 0, 1, 24'h000000, 0, 0, 0};
    vecs[19] = '{0, 0, 24'h000000, 1, 1, 24'h010100, 0, 0, 0};
    vecs[20] = '{0, 1, 24'h015900, 0, 0, 24'h015900, 0, 0, 0};
    vecs[21] = '{0, 0, 24'h000000, 1, 0, 24'h010000, 0, 0, 0};

    modelReset();
    #12;
    checkModel("por");
    #1 reset = 1'b0;

    // Directed table against the 24h instance
    foreach (vecs[i]) begin
      setIn(vecs[i].run, vecs[i].lv, vecs[i].lt, 1'b0, vecs[i].im, vecs[i].ih);
      cycle();
      check($sformatf("vec%0d", i), 32'({time24, st24, dt24, err24}),
            32'({vecs[i].expTime, vecs[i].expSt, vecs[i].expDt, vecs[i].expErr}));
    end

    // 12h noon and midnight rollovers
    setIn(0, 1, 24'h115959, 0, 0, 0);
    cycle();
    setIn(1, 0, 24'h000000, 0, 0, 0);
    repeat (TickDiv) cycle();
    check("noon12", 32'({time12, pm12, dt12}), 32'({24'h120000, 1'b1, 1'b0}));
    setIn(0, 1, 24'h115959, 1, 0, 0);
    cycle();
    setIn(1, 0, 24'h000000, 0, 0, 0);
    repeat (TickDiv) cycle();
    check("midnight12", 32'({time12, pm12, dt12}), 32'({24'h120000, 1'b0, 1'b1}));
    setIn(0, 1, 24'h001000, 0, 0, 0);
    cycle();
    check("badHour12", 32'({time12, err12}), 32'({24'h120000, 1'b1}));

    // Reset mid-count with prescaler at 2
    setIn(0, 1, 24'h123456, 0, 0, 0);
    cycle();
    setIn(1, 0, 24'h000000, 0, 0, 0);
    repeat (2) cycle();
    reset = 1'b1;
    #1;
    modelReset();
    checkModel("midReset");
    check("resetTime", 32'({time24, time12}), 32'({24'h000000, 24'h120000}));
    #1 reset = 1'b0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      n++;
      if (st24) break;
    end
    check("firstTick", 32'(n), 32'(TickDiv));

    // Randomized traffic against the model
    runBurst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 20 == 0) runBurst = ($urandom_range(0, 2) != 0);
      setIn(runBurst, $urandom_range(0, 4) == 0, randTime(), 1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0);
      cycle();
    end
    setIn(0, 0, 24'h000000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_clock_core.md
BCD_CLOCK_CORE -- requirements
Module: bcd_clock_core

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000: clk cycles per second; legal range 2 or more.
REQ-002 SHALL have parameter MODE_12H, default 0: 0 = 24-hour (00-23), 1 = 12-hour (01-12 plus pm flag).
REQ-003 SHALL have port clk  in  1  system clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  in  1  1 = timekeeping advances, 0 = hold.
REQ-006 SHALL have port load_valid  in  1  load request.
REQ-007 SHALL have port load_ready  out  1  load can be accepted; equals !run.
REQ-008 SHALL have port load_time  in  24  BCD HH:MM:SS, [23:20]=H tens ... [3:0]=S units.
REQ-009 SHALL have port load_pm  in  1  pm value to load; ignored when MODE_12H=0.
REQ-010 SHALL have port inc_min  in  1  single-cycle pulse: minutes +1.
REQ-011 SHALL have port inc_hour  in  1  single-cycle pulse: hours +1.
REQ-012 SHALL have port time_out  out  24  current BCD time, same layout as load_time.
REQ-013 SHALL have port pm  out  1  pm flag; constant 0 when MODE_12H=0.
REQ-014 SHALL have port sec_tick  out  1  1-cycle pulse in the cycle the time advances by a second.
REQ-015 SHALL have port day_tick  out  1  1-cycle pulse on day rollover.
REQ-016 SHALL have port load_err  out  1  1-cycle pulse when a handshaked load is rejected.

Function
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 while run=1, wrap to 0, and hold its value while run=0.
REQ-018 Seconds SHALL advance in the cycle after the prescaler reaches TICK_DIV-1, with sec_tick=1 in that same update.
REQ-019 Advance SHALL be a BCD cascade: S 0-9, S tens 0-5, M units 0-9, M tens 0-5, then hour.
REQ-020 In 24h mode, hours SHALL advance from 23 to 00; day_tick SHALL pulse on 23:59:59 -> 00:00:00.
REQ-021 In 12h mode, hours SHALL run 12,01..11,12; pm SHALL toggle on 11:59:59 -> 12:00:00.
REQ-022 In 12h mode, day_tick SHALL pulse only on 11:59:59 PM -> 12:00:00 AM.
REQ-023 A load SHALL be accepted only when load_valid=1 and load_ready=1; once accepted, time_out and pm update on the next edge and the prescaler clears to 0.
REQ-024 A load SHALL be rejected when any nibble exceeds 9, S or M tens exceed 5, or the hour is outside the mode range; on reject, state is unchanged and load_err=1 for one cycle.
REQ-025 load_valid while load_ready=0 SHALL be ignored, with no load_err.
REQ-026 inc_min SHALL wrap minutes 59 -> 00 with no carry into hours; seconds and prescaler are unchanged.
REQ-027 inc_hour SHALL wrap hours per mode with no day_tick; in 12h mode it toggles pm on 11 -> 12.
REQ-028 inc_min and inc_hour SHALL act regardless of run.
REQ-029 Same-cycle priority SHALL be: accepted load > inc_hour/inc_min > second advance.
REQ-030 A second advance lost to a higher-priority event SHALL be dropped, not deferred; sec_tick=0 in that cycle.
REQ-031 inc_hour and inc_min asserted together SHALL both apply, independently, with no carry.
REQ-032 time_out, pm and all pulse outputs SHALL be driven from registers, giving zero combinational input-to-output paths except load_ready.

Reset
REQ-033 reset=1 SHALL force immediately: prescaler=0, sec_tick=0, day_tick=0, load_err=0.
REQ-034 reset=1 SHALL force immediately: time_out=00:00:00 in 24h mode, or 12:00:00 with pm=0 in 12h mode.
REQ-035 Reset asserted mid-load or mid-count SHALL abort the operation; no pulse output may fire in the first cycle after release.

Structure
REQ-036 A shared package SHALL hold the BCD field width (4), the field limit constants (5, 9, 23, 12) and the 24-bit field bit positions.
REQ-037 One sub-module, bcd_digit_counter, SHALL be used: parameter MAX; ports inc, clr, load, load_val; outputs value and carry (carry asserted when inc occurs at MAX).
REQ-038 Hour wrap, pm and validation logic SHALL live in bcd_clock_core; the prescaler SHALL be inline.

Verification (TICK_DIV=4)
REQ-039 Scenario: 24h, run=0, load 23:59:58 -> ack'd; run=1 for 8 cycles -> 23:59:59 then 00:00:00, day_tick pulses exactly once.
REQ-040 Scenario: 12h, load 11:59:59 pm=0, run 4 cycles -> 12:00:00 pm=1, day_tick=0; repeat from 11:59:59 pm=1 -> pm=0, day_tick=1.
REQ-041 Scenario: load 24:00:00 (24h) or 00:10:00 (12h) or 12:6A:00 -> load_err pulse, time unchanged.
REQ-042 Scenario: run=1, load_valid=1 -> load_ready=0, no load, no load_err.
REQ-043 Scenario: at 10:59:30, inc_min and a second advance in the same cycle -> 10:00:30, sec_tick=0; inc_hour at 23 (24h) -> 00, no day_tick.
REQ-044 Scenario: reset pulsed mid-count at prescaler=2 -> outputs reach reset values immediately; first sec_tick occurs 4 cycles after release with run=1.
